fifo_stream_drain: RTL and testbench
====================================

# fifo_stream_drain

Read-side drain stage placed directly downstream of the team's synchronous FIFO. It issues `fifo_rd_en` only when a read is safe, captures the FIFO's registered `data_out` one cycle after each read, and re-presents the words on a valid/ready stream through a small skid buffer. It also frames the stream into fixed-length packets (`m_last`) and keeps a completed-packet counter. The FIFO never sees a read while empty, and back-pressure on `m_ready` never drops or duplicates a word.

## Interface
- `DATA_W`, 16: word width; equals the FIFO width.
- `SKID_DEPTH`, 3: skid buffer entries; minimum 3, required for full throughput.
- `PKT_LEN`, 4: words per packet; range 1..255.
- `clk` in 1: clock.
- `rst_n` in 1: reset; asynchronous, active-low.
- `enable` in 1: permits new FIFO reads.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_data_out` in DATA_W: FIFO read data; valid the cycle after a read.
- `fifo_rd_en` out 1: FIFO read strobe.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: downstream accept.
- `m_data` out DATA_W: output word.
- `m_last` out 1: final word of a packet.
- `pkt_cnt` out 16: completed packets; wraps modulo 2^16.

## Operation
- **Internal state:**
  - `occ`: skid occupancy, 0..SKID_DEPTH.
  - `inflight`: 1 bit; registered copy of `fifo_rd_en`.
  - `beat`: 0..PKT_LEN-1.
  - Circular buffer with wrapping read/write pointers.
- **Read issue:** `fifo_rd_en = rst_n && enable && !fifo_empty && (occ + inflight < SKID_DEPTH)`.
  - The condition is combinational, with no path from `m_ready`.
- **Capture:**
  - When `inflight` is 1, write `fifo_data_out` into the buffer at the write pointer on that edge.
  - Capture is unconditional. Space is guaranteed by the issue rule.
- **Pop:** a transfer occurs on any edge where `m_valid && m_ready`. On a transfer, advance the read pointer.
- **Occupancy update:** `occ` next = `occ + capture - pop`. A simultaneous capture and pop leaves `occ` unchanged.
- **Stream outputs:**
  - `m_valid = (occ != 0)`.
  - `m_data` = buffer entry at the read pointer.
  - `m_data` and `m_last` hold stable while `m_valid && !m_ready`.
- **Packet framing:**
  - `m_last = m_valid && (beat == PKT_LEN-1)`.
  - On each transfer, `beat` increments and wraps to 0 after PKT_LEN-1.
  - A transfer with `m_last = 1` increments `pkt_cnt`.
  - With PKT_LEN = 1, every word is last.
- **Enable deassert:** stops new reads only. The in-flight word is still captured, and buffered words still drain. `beat` is preserved, so a packet may span enable gaps.

## Timing
- **Reset values (while `rst_n` is low):** `fifo_rd_en` = 0, `m_valid` = 0, `m_last` = 0, `m_data` = 0, `pkt_cnt` = 0, `occ` = 0, `inflight` = 0, `beat` = 0.
- **Reset mid-operation:**
  - Buffered and in-flight words are discarded.
  - The FIFO is reset by the same `rst_n`, so its state stays consistent with this block.
- **Latency:** for `fifo_rd_en` high in cycle N, the word is on `fifo_data_out` in cycle N+1 and is presented with `m_valid` = 1 in cycle N+2.
- **Throughput:**
  - With `m_ready` held at 1 and the FIFO non-empty, `fifo_rd_en` stays high every cycle and one word transfers per cycle from N+2 onward.
  - Steady state is `occ` = 1, `inflight` = 1.
- **Back-pressure:**
  - With `m_ready` = 0, reads continue until `occ + inflight` = SKID_DEPTH.
  - After that, `fifo_rd_en` = 0 and nothing is lost.
- **Empty boundary:** the FIFO's `fifo_empty` updates one edge after the read that emptied it, so `fifo_rd_en` never asserts while the FIFO is empty (no underflow).
- **Order:** words are delivered in FIFO order, with no reordering or duplication.

## Test plan
1. **Basic latency.** Stimulus: reset, preload FIFO with 0x0001..0x0004, `enable` = 1, `m_ready` = 1. Required:
   - `fifo_rd_en` high for 4 consecutive cycles starting the cycle after `fifo_empty` falls.
   - `m_data` = 0x0001..0x0004 on 4 consecutive cycles, starting 2 cycles after the first read.
   - `m_last` on 0x0004; `pkt_cnt` = 1.
2. **Back-pressure.** Stimulus: FIFO holds 8 words, `m_ready` = 0. Required:
   - Exactly 3 reads are issued, then `fifo_rd_en` stays 0.
   - `m_data` holds the first word stable.
   - After raising `m_ready`, all 8 words emerge in order.
3. **Empty boundary.** Stimulus: FIFO holds 1 word, `m_ready` = 1. Required:
   - Exactly one `fifo_rd_en` pulse.
   - FIFO `underflow` is never asserted.
   - `m_valid` is high for exactly 1 cycle.
4. **Packet framing.** Stimulus: PKT_LEN = 3, 7 words, random `m_ready`. Required:
   - `m_last` on words 3 and 6.
   - `pkt_cnt` = 2 at the end.
   - After the 7th word, `beat` = 1.
5. **Enable gap.** Stimulus: deassert `enable` in the same cycle as a read. Required:
   - The in-flight word is still delivered.
   - No further reads occur until `enable` returns.
   - `beat` continues from its previous value.
6. **Reset mid-operation.** Stimulus: assert `rst_n` low with `occ` = 2 and `inflight` = 1. Required:
   - All outputs are immediately at their reset values.
   - The first word after release is the FIFO's new first write.

Source files
------------

// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain: drains a registered-output FIFO into a valid/ready stream through a skid buffer,
// framing words into fixed-length packets and counting completed packets.
module fifo_stream_drain #(
  parameter int DATA_W     = 16,
  parameter int SKID_DEPTH = 3,
  parameter int PKT_LEN    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data_out,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [15:0]       pkt_cnt
);
  localparam int PW = $clog2(SKID_DEPTH);
  localparam int OW = $clog2(SKID_DEPTH + 1) + 1;
  logic [DATA_W-1:0] buf_q [SKID_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [OW-1:0] occ;
  logic inflight, pop;
  logic [7:0] beat;
  // A read reserves a slot one cycle before its data lands, so in-flight words count as occupied
  assign fifo_rd_en = rst_n && enable && !fifo_empty && ((occ + OW'(inflight)) < OW'(SKID_DEPTH));
  assign m_valid = occ != '0;
  assign m_data = m_valid ? buf_q[rd_ptr] : '0;
  assign m_last = m_valid && beat == 8'(PKT_LEN - 1);
  assign pop = m_valid && m_ready;
  assign wr_nxt = wr_ptr == PW'(SKID_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
  assign rd_nxt = rd_ptr == PW'(SKID_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
  always_ff @(posedge clk)
    if (inflight) buf_q[wr_ptr] <= fifo_data_out;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      occ <= '0;
      inflight <= 1'b0;
      beat <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      pkt_cnt <= '0;
    end else begin
      inflight <= fifo_rd_en;
      occ <= occ + OW'(inflight) - OW'(pop);
      if (inflight) wr_ptr <= wr_nxt;
      if (pop) begin
        rd_ptr <= rd_nxt;
        beat <= m_last ? '0 : beat + 1'b1;
        pkt_cnt <= pkt_cnt + 16'(m_last);
      end
    end
endmodule

// File: tb/tb_fifo_stream_drain.sv
// tb_fifo_stream_drain: two drain instances (packet lengths 4 and 3) behind one FIFO model,
// checked every cycle against a word-count model of the stream.
module tb_fifo_stream_drain;
  localparam int SD = 3;
  logic clk = 0, rst_n = 1, enable = 0, m_ready = 0, wr_en = 0;
  logic [15:0] wr_data = 0, fifo_data_out;
  logic fifo_empty, rd4, rd3, v4, v3, l4, l3;
  logic [15:0] d4, d3, p4, p3;
  int total = 0, bad = 0;
  logic [15:0] mem [256];
  logic [7:0] wp, rp;
  int rd_cnt, xfer, wcnt;
  logic last_rd;
  logic [15:0] wl [4096];

  always #5 clk = ~clk;

  fifo_stream_drain #(.DATA_W(16), .SKID_DEPTH(SD), .PKT_LEN(4)) u4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
    .fifo_rd_en(rd4), .m_valid(v4), .m_ready(m_ready), .m_data(d4), .m_last(l4), .pkt_cnt(p4));
  fifo_stream_drain #(.DATA_W(16), .SKID_DEPTH(SD), .PKT_LEN(3)) u3 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
    .fifo_rd_en(rd3), .m_valid(v3), .m_ready(m_ready), .m_data(d3), .m_last(l3), .pkt_cnt(p3));

  // Synchronous FIFO with registered read data, shared by both instances
  assign fifo_empty = wp == rp;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= 0;
      rp <= 0;
      fifo_data_out <= 0;
    end else begin
      if (wr_en) begin
        mem[wp] <= wr_data;
        wp <= wp + 8'd1;
      end
      if (rd4) begin
        fifo_data_out <= mem[rp];
        rp <= rp + 8'd1;
      end
    end

  // Stream model: output word n is written word n; words in the block = reads - transfers
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_cnt <= 0;
      xfer <= 0;
      last_rd <= 0;
      wcnt <= 0;
    end else begin
      rd_cnt <= rd_cnt + int'(rd4);
      last_rd <= rd4;
      xfer <= xfer + int'(v4 && m_ready);
      if (wr_en) begin
        wl[wcnt[11:0]] <= wr_data;
        wcnt <= wcnt + 1;
      end
    end

  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  task automatic check_all();
    logic er, ev;
    logic [15:0] ed;
    if (!rst_n) begin
      cmp("rst_rd", 32'({rd4, rd3}), 0);
      cmp("rst_valid", 32'({v4, v3}), 0);
      cmp("rst_last", 32'({l4, l3}), 0);
      cmp("rst_data", 32'({d4, d3}), 0);
      cmp("rst_pkt", 32'({p4, p3}), 0);
    end else begin
      er = enable && !fifo_empty && (rd_cnt - xfer < SD);
      ev = (rd_cnt - int'(last_rd)) > xfer;
      ed = ev ? wl[xfer[11:0]] : 16'h0;
      cmp("rd_en4", 32'(rd4), 32'(er));
      cmp("rd_en3", 32'(rd3), 32'(er));
      cmp("valid4", 32'(v4), 32'(ev));
      cmp("valid3", 32'(v3), 32'(ev));
      cmp("data4", 32'(d4), 32'(ed));
      cmp("data3", 32'(d3), 32'(ed));
      cmp("last4", 32'(l4), 32'(ev && xfer % 4 == 3));
      cmp("last3", 32'(l3), 32'(ev && xfer % 3 == 2));
      cmp("pkt4", 32'(p4), 32'(16'(xfer / 4)));
      cmp("pkt3", 32'(p3), 32'(16'(xfer / 3)));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] w);
    wr_en = 1;
    wr_data = w;
    tick();
    wr_en = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic drain(input bit rnd);
    int n = 0;
    while (!(fifo_empty && rd_cnt == xfer) && n < 300) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    m_ready = 1;
    cmp("drain_timeout", 32'(n < 300), 1);
  endtask

  initial begin
    int r0, x0, vc, n;
    #1 rst_n = 0;
    tick();
    rst_n = 1;
    tick();
    // Basic latency with four preloaded words
    m_ready = 1;
    for (int i = 1; i <= 4; i++) wr(16'(i));
    enable = 1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check_all();
      cmp("t1_rd", 32'(rd4), 32'(k < 4));
      cmp("t1_valid", 32'(v4), 32'(k >= 2 && k < 6));
      if (k >= 2 && k < 6) begin
        cmp("t1_data", 32'(d4), 32'(k - 1));
        cmp("t1_last", 32'(l4), 32'(k == 5));
      end
      @(posedge clk);
      #1;
    end
    cmp("t1_pkt", 32'(p4), 1);
    // Back-pressure: three reads fill the skid, first word held
    enable = 0;
    m_ready = 0;
    for (int i = 0; i < 8; i++) wr(16'h100 + 16'(i));
    r0 = rd_cnt;
    x0 = xfer;
    enable = 1;
    repeat (8) tick();
    cmp("t2_reads", 32'(rd_cnt - r0), 3);
    cmp("t2_hold", 32'(d4), 32'h100);
    cmp("t2_rd_off", 32'(rd4), 0);
    drain(0);
    cmp("t2_out", 32'(xfer - x0), 8);
    // Empty boundary: one word, one read, one valid cycle
    r0 = rd_cnt;
    vc = 0;
    wr(16'h0abc);
    for (int i = 0; i < 6; i++) begin
      vc += int'(v4);
      tick();
    end
    cmp("t3_reads", 32'(rd_cnt - r0), 1);
    cmp("t3_valid_cycles", 32'(vc), 1);
    // Packet framing with random ready
    do_reset();
    for (int i = 0; i < 7; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      wr(16'h300 + 16'(i));
    end
    drain(1);
    cmp("t4_pkt3", 32'(p3), 2);
    cmp("t4_pkt4", 32'(p4), 1);
    cmp("t4_beat3", 32'(u3.beat), 1);
    // Enable gap right after a read
    enable = 0;
    for (int i = 0; i < 5; i++) wr(16'h500 + 16'(i));
    enable = 1;
    tick();
    enable = 0;
    r0 = rd_cnt;
    x0 = xfer;
    repeat (6) tick();
    cmp("t5_noread", 32'(rd_cnt - r0), 0);
    cmp("t5_inflight_out", 32'(xfer - x0), 1);
    enable = 1;
    drain(0);
    // Reset with two buffered words and one in flight
    m_ready = 0;
    enable = 0;
    for (int i = 0; i < 6; i++) wr(16'h600 + 16'(i));
    enable = 1;
    repeat (3) tick();
    cmp("t6_pre", 32'(rd_cnt - xfer), 3);
    rst_n = 0;
    #1;
    cmp("t6_rst_rd", 32'(rd4), 0);
    cmp("t6_rst_valid", 32'(v4), 0);
    cmp("t6_rst_data", 32'(d4), 0);
    cmp("t6_rst_pkt", 32'(p4), 0);
    tick();
    rst_n = 1;
    enable = 0;
    m_ready = 1;
    wr(16'hbeef);
    enable = 1;
    n = 0;
    while (!v4 && n < 10) begin
      tick();
      n++;
    end
    cmp("t6_first", 32'(d4), 32'hbeef);
    drain(0);
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      wr_en = ($urandom_range(0, 2) != 0) && (8'(wp - rp) < 8'd200);
      wr_data = 16'($urandom);
      enable = $urandom_range(0, 3) != 0;
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    wr_en = 0;
    enable = 1;
    drain(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
